lcfg_cfgo_bridge: RTL and testbench

Parametrised TV80 I/O-mapped master for the outgoing configuration bus. It replaces the fixed 32-bit config driver with a self-contained 16-byte I/O window. The window holds address, control, status and `DBYTES` data registers. Triggered accesses launch non-posted config reads and writes, with optional address auto-increment and an optional watchdog timeout. It sits between the TV80 I/O bus and the system `cfgo_*` configuration interface.

---
 rtl/lcfg_cfgo_bridge.sv | 140 ++++++++++++++
 tb/tb_lcfg_cfgo_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lcfg_cfgo_bridge.sv
// lcfg_cfgo_bridge: TV80 16-byte I/O window mastering the cfgo config bus.
// Define LCFG_CFGO_TIMEOUT_EN to add the REQ watchdog and STATUS timeout bit.
module lcfg_cfgo_bridge #(
  parameter logic [7:0] io_base_addr = 8'h00,
  parameter int DBYTES = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         addr,
  input  logic [7:0]          cd_wdata,
  output logic [7:0]          cd_rdata,
  input  logic                mreq_n,
  input  logic                iorq_n,
  input  logic                rd_n,
  input  logic                wr_n,
  output logic                cfgo_wait_n,
  output logic                cfgo_irdy,
  input  logic                cfgo_trdy,
  output logic [15:0]         cfgo_addr,
  output logic                cfgo_write,
  output logic [8*DBYTES-1:0] cfgo_wr_data,
  input  logic [8*DBYTES-1:0] cfgo_rd_data
);
  localparam logic [3:0] LAST = 4'(4 + DBYTES - 1);
  typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, DONE = 3'b100} state_t;
  state_t state_q, state_d;
  logic acc_q, autoinc_q, autoinc_d, err_q, err_d, write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [8*DBYTES-1:0] chold_q, chold_d;
  logic [3:0] off;
  logic sel, acc, first, wr_en, trig_wr, trig_rd, trig, tmo_bit;
  logic [7:0] rdata;
  logic unused_addr_hi;
`ifdef LCFG_CFGO_TIMEOUT_EN
  logic tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;
  assign tmo_bit = tmo_q;
`else
  assign tmo_bit = 1'b0;
`endif
  assign unused_addr_hi = ^addr[15:8];
  assign off = addr[3:0];
  assign sel = !iorq_n & mreq_n & (addr[7:4] == io_base_addr[7:4]);
  assign acc = sel & (!rd_n | !wr_n);
  assign first = acc & !acc_q;
  assign wr_en = first & !wr_n;
  assign trig_wr = !wr_n & (off == LAST);
  assign trig_rd = !rd_n & (off == 4'd4);
  assign trig = trig_wr | trig_rd;
  // Stall only trigger accesses, and release as soon as the transfer is done.
  assign cfgo_wait_n = !(acc & trig & (state_q != DONE));
  assign cfgo_irdy = (state_q == REQ);
  assign cfgo_addr = addr_q;
  assign cfgo_write = write_q;
  assign cfgo_wr_data = chold_q;
  always_comb begin
    rdata = 8'h00;
    if (off == 4'd0) rdata = addr_q[7:0];
    if (off == 4'd1) rdata = addr_q[15:8];
    if (off == 4'd2) rdata = {7'd0, autoinc_q};
    if (off == 4'd3) rdata = {1'b0, 3'(DBYTES - 1), 1'b0, tmo_bit, err_q, state_q == REQ};
    for (int i = 0; i < DBYTES; i++)
      if (off == 4'(4 + i)) rdata = chold_q[8*i +: 8];
  end
  assign cd_rdata = sel ? rdata : 8'h00;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    write_d = write_q;
    chold_d = chold_q;
    autoinc_d = autoinc_q;
    err_d = err_q;
`ifdef LCFG_CFGO_TIMEOUT_EN
    tmo_d = tmo_q;
    cnt_d = 16'd0;
`endif
    if (wr_en) begin
      if (off == 4'd0) addr_d[7:0] = cd_wdata;
      if (off == 4'd1) addr_d[15:8] = cd_wdata;
      if (off == 4'd2) begin
        autoinc_d = cd_wdata[0];
        if (cd_wdata[1]) err_d = 1'b0;
`ifdef LCFG_CFGO_TIMEOUT_EN
        if (cd_wdata[1]) tmo_d = 1'b0;
`endif
      end
      for (int i = 0; i < DBYTES; i++)
        if (off == 4'(4 + i)) chold_d[8*i +: 8] = cd_wdata;
    end
    // Error set below comes after the CLR_ERR handling, so set wins.
    case (state_q)
      IDLE: if (first & trig) begin
        state_d = REQ;
        write_d = trig_wr;
      end
      REQ: if (cfgo_trdy) begin
        state_d = DONE;
        if (!write_q) chold_d = cfgo_rd_data;
        if (autoinc_q) addr_d = addr_q + 16'(DBYTES);
      end
`ifdef LCFG_CFGO_TIMEOUT_EN
      else if (cnt_q == 16'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d = 1'b1;
        tmo_d = 1'b1;
        if (!write_q) chold_d = '1;
      end else cnt_d = cnt_q + 16'd1;
`endif
      DONE: if (!acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q <= 1'b0;
      addr_q <= 16'd0;
      write_q <= 1'b0;
      chold_q <= '0;
      autoinc_q <= 1'b0;
      err_q <= 1'b0;
`ifdef LCFG_CFGO_TIMEOUT_EN
      tmo_q <= 1'b0;
      cnt_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc;
      addr_q <= addr_d;
      write_q <= write_d;
      chold_q <= chold_d;
      autoinc_q <= autoinc_d;
      err_q <= err_d;
`ifdef LCFG_CFGO_TIMEOUT_EN
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
`endif
    end
endmodule

// File: tb/tb_lcfg_cfgo_bridge.sv
// tb_lcfg_cfgo_bridge: directed bench for a 4-byte bridge at 0x40 and a 2-byte bridge at 0x50.
module tb_lcfg_cfgo_bridge;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] addr = 16'h0;
  logic [7:0] cd_wdata = 8'h0;
  logic mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] rdata_a, rdata_b;
  logic wait_a, wait_b, irdy_a, irdy_b, cwr_a, cwr_b;
  logic trdy_a = 1'b0, trdy_b = 1'b0;
  logic [15:0] caddr_a, caddr_b;
  logic [31:0] wdata_a, rddata_a = 32'h0;
  logic [15:0] wdata_b, rddata_b = 16'h0;
  lcfg_cfgo_bridge #(.io_base_addr(8'h40), .DBYTES(4), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .addr(addr), .cd_wdata(cd_wdata), .cd_rdata(rdata_a),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .cfgo_wait_n(wait_a),
    .cfgo_irdy(irdy_a), .cfgo_trdy(trdy_a), .cfgo_addr(caddr_a), .cfgo_write(cwr_a),
    .cfgo_wr_data(wdata_a), .cfgo_rd_data(rddata_a));
  lcfg_cfgo_bridge #(.io_base_addr(8'h50), .DBYTES(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .addr(addr), .cd_wdata(cd_wdata), .cd_rdata(rdata_b),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .cfgo_wait_n(wait_b),
    .cfgo_irdy(irdy_b), .cfgo_trdy(trdy_b), .cfgo_addr(caddr_b), .cfgo_write(cwr_b),
    .cfgo_wr_data(wdata_b), .cfgo_rd_data(rddata_b));
  typedef struct {logic wr; logic [15:0] a; logic [63:0] d;} xfer_t;
  xfer_t qa[$], qb[$];
  xfer_t ea, eb;
  int n_assert = 0, n_fail = 0, dly_a = 0, dly_b = 0, nx_a = 0, nx_b = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // Config targets: complete dly cycles after irdy is first seen.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk); #2;
      if (!irdy_a) begin trdy_a = 1'b0; c = 0; end
      else if (!trdy_a) begin c++; if (c > dly_a) trdy_a = 1'b1; end
    end
  end
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk); #2;
      if (!irdy_b) begin trdy_b = 1'b0; c = 0; end
      else if (!trdy_b) begin c++; if (c > dly_b) trdy_b = 1'b1; end
    end
  end
  initial forever begin
    @(negedge clk);
    if (irdy_a && trdy_a) begin
      nx_a++;
      chk("a_xfer_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_xfer_write", cwr_a, ea.wr);
        chk("a_xfer_addr", caddr_a, ea.a);
        if (ea.wr) chk("a_xfer_data", wdata_a, ea.d);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (irdy_b && trdy_b) begin
      nx_b++;
      chk("b_xfer_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_xfer_write", cwr_b, eb.wr);
        chk("b_xfer_addr", caddr_b, eb.a);
        if (eb.wr) chk("b_xfer_data", wdata_b, eb.d);
      end
    end
  end
  task automatic io(input logic wr, input logic [7:0] a, input logic [7:0] d,
                    output logic [7:0] q, output int w);
    @(posedge clk); #1;
    addr = {8'h00, a}; iorq_n = 1'b0; mreq_n = 1'b1;
    if (wr) begin wr_n = 1'b0; cd_wdata = d; end else rd_n = 1'b0;
    w = 0;
    @(negedge clk);
    while (!(wait_a & wait_b) && w < 100) begin @(negedge clk); w++; end
    chk($sformatf("io_%h_wait_bound", a), w < 100, 1);
    q = (a[7:4] == 4'h5) ? rdata_b : rdata_a;
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int expw);
    logic [7:0] q;
    int w;
    io(1'b1, a, d, q, w);
    chk($sformatf("wr_%h_waits", a), w, expw);
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input int expw);
    logic [7:0] q;
    int w;
    io(1'b0, a, 8'h00, q, w);
    chk($sformatf("rd_%h_data", a), q, exp);
    chk($sformatf("rd_%h_waits", a), w, expw);
  endtask
  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irdy", irdy_a, 0);
    chk("rst_write", cwr_a, 0);
    chk("rst_addr", caddr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_wait", wait_a, 1);
    chk("rst_irdy_b", irdy_b, 0);
    @(negedge clk) reset_n = 1'b1;
    rd(8'h43, 8'h30, 0);
    rd(8'h42, 8'h00, 0);
    // Config write of four bytes to 0x1234
    dly_a = 3;
    wr(8'h40, 8'h34, 0);
    wr(8'h41, 8'h12, 0);
    wr(8'h44, 8'h11, 0);
    wr(8'h45, 8'h22, 0);
    wr(8'h46, 8'h33, 0);
    chk("wr_no_early_xfer", nx_a, 0);
    qa.push_back('{1'b1, 16'h1234, 64'h44332211});
    wr(8'h47, 8'h44, 5);
    chk("wr_one_xfer", nx_a, 1);
    rd(8'h40, 8'h34, 0);
    rd(8'h41, 8'h12, 0);
    rd(8'h45, 8'h22, 0);
    // Config read, remaining bytes come from the holding register
    dly_a = 0;
    rddata_a = 32'hDEADBEEF;
    qa.push_back('{1'b0, 16'h1234, 64'h0});
    rd(8'h44, 8'hEF, 2);
    n0 = nx_a;
    rd(8'h45, 8'hBE, 0);
    rd(8'h46, 8'hAD, 0);
    rd(8'h47, 8'hDE, 0);
    chk("rd_no_new_xfer", nx_a, n0);
    chk("rd_irdy_idle", irdy_a, 0);
    rd(8'h43, 8'h30, 0);
    // Unused offsets
    wr(8'h48, 8'hFF, 0);
    rd(8'h48, 8'h00, 0);
    rd(8'h4F, 8'h00, 0);
    // Auto-increment wraps modulo 2^16
    wr(8'h42, 8'h01, 0);
    rd(8'h42, 8'h01, 0);
    wr(8'h40, 8'hFC, 0);
    wr(8'h41, 8'hFF, 0);
    rddata_a = 32'h01020304;
    qa.push_back('{1'b0, 16'hFFFC, 64'h0});
    rd(8'h44, 8'h04, 2);
    chk("autoinc_wrap", caddr_a, 16'h0000);
    qa.push_back('{1'b0, 16'h0000, 64'h0});
    rd(8'h44, 8'h04, 2);
    chk("autoinc_step", caddr_a, 16'h0004);
`ifdef LCFG_CFGO_TIMEOUT_EN
    dly_a = 1000;
    rd(8'h44, 8'hFF, 17);
    chk("tmo_irdy_low", irdy_a, 0);
    chk("tmo_no_autoinc", caddr_a, 16'h0004);
    rd(8'h43, 8'h36, 0);
    wr(8'h42, 8'h02, 0);
    rd(8'h43, 8'h30, 0);
    rd(8'h42, 8'h00, 0);
`else
    wr(8'h42, 8'h00, 0);
`endif
    // Asynchronous reset while a write request is outstanding
    dly_a = 1000;
    wr(8'h40, 8'h78, 0);
    wr(8'h41, 8'h56, 0);
    @(posedge clk); #1;
    addr = 16'h0047; cd_wdata = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
    for (int k = 0; k < 10 && !irdy_a; k++) @(negedge clk);
    chk("rreq_irdy_up", irdy_a, 1);
    chk("rreq_write_up", cwr_a, 1);
    #2;
    reset_n = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
    #1;
    chk("rreq_irdy", irdy_a, 0);
    chk("rreq_write", cwr_a, 0);
    chk("rreq_addr", caddr_a, 0);
    chk("rreq_wdata", wdata_a, 0);
    chk("rreq_wait", wait_a, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    dly_a = 0;
    rd(8'h43, 8'h30, 0);
    // Two-byte bridge
    dly_b = 1;
    wr(8'h50, 8'hCD, 0);
    wr(8'h51, 8'hAB, 0);
    wr(8'h54, 8'h34, 0);
    qb.push_back('{1'b1, 16'hABCD, 64'h1234});
    wr(8'h55, 8'h12, 3);
    chk("b_one_xfer", nx_b, 1);
    rd(8'h56, 8'h00, 0);
    rd(8'h57, 8'h00, 0);
    rd(8'h5F, 8'h00, 0);
    rd(8'h53, 8'h10, 0);
    rddata_b = 16'hCAFE;
    qb.push_back('{1'b0, 16'hABCD, 64'h0});
    rd(8'h54, 8'hFE, 3);
    rd(8'h55, 8'hCA, 0);
    chk("b_two_xfers", nx_b, 2);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
